// File: rtl/uar_pkt_rx.sv
// Oversampled 8N1 packet receiver: majority-vote bit decisions, bytes gathered into
// a packet closed by an idle gap or when full, delivered through a valid/ready holding register.
module uar_pkt_rx #(
    parameter int CLK_PER_SAMP = 423,
    parameter int SAMP_PER_BIT = 16,
    parameter int PKT_BYTES    = 21,
    parameter int IDLE_SAMPS   = 320
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             rx_in,
    output logic [8*PKT_BYTES-1:0]           data_out,
    output logic [$clog2(PKT_BYTES+1)-1:0]   len_out,
    output logic                             frame_err_out,
    output logic                             valid_out,
    input  logic                             ready_in,
    output logic                             overrun_out
);
    localparam int CW = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
    localparam int SW = $clog2(SAMP_PER_BIT);
    localparam int IW = $clog2(IDLE_SAMPS + 1);
    localparam int LW = $clog2(PKT_BYTES + 1);
    localparam int BW = 8 * PKT_BYTES;

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLK_PER_SAMP - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMP_PER_BIT - 1);
    localparam logic [SW-1:0] SAMP_A    = SW'(SAMP_PER_BIT / 2 - 1);
    localparam logic [SW-1:0] SAMP_B    = SW'(SAMP_PER_BIT / 2);
    localparam logic [SW-1:0] SAMP_C    = SW'(SAMP_PER_BIT / 2 + 1);
    localparam logic [IW-1:0] IDLE_END  = IW'(IDLE_SAMPS);
    localparam logic [LW-1:0] LEN_FULL  = LW'(PKT_BYTES);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    state_t         state_q, state_nx;
    logic [1:0]     sync_q;
    logic [CW-1:0]  clk_cnt_q;
    logic [SW-1:0]  samp_q, samp_nx;
    logic [2:0]     bit_q, bit_nx;
    logic [7:0]     shreg_q, shreg_nx;
    logic [LW-1:0]  byte_cnt_q, byte_cnt_nx;
    logic [IW-1:0]  idle_q, idle_nx;
    logic           err_q, err_nx;
    logic           ret_gap_q, ret_gap_nx;
    logic           s0_q, s0_nx, s1_q, s1_nx;
    logic [BW-1:0]  buf_q, buf_nx;
    logic           close_nx, close_q;
    logic           rx_s, tick, maj;

    assign rx_s = sync_q[1];
    assign tick = (clk_cnt_q == CLK_LAST);
    assign maj  = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sync_q     <= 2'b11;
            clk_cnt_q  <= '0;
            state_q    <= IDLE;
            samp_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            idle_q     <= '0;
            err_q      <= 1'b0;
            ret_gap_q  <= 1'b0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            buf_q      <= '0;
            close_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx_in};
            clk_cnt_q  <= tick ? '0 : clk_cnt_q + CW'(1);
            state_q    <= state_nx;
            samp_q     <= samp_nx;
            bit_q      <= bit_nx;
            shreg_q    <= shreg_nx;
            byte_cnt_q <= byte_cnt_nx;
            idle_q     <= idle_nx;
            err_q      <= err_nx;
            ret_gap_q  <= ret_gap_nx;
            s0_q       <= s0_nx;
            s1_q       <= s1_nx;
            buf_q      <= buf_nx;
            close_q    <= close_nx;
        end
    end

    always_comb begin
        state_nx    = state_q;
        samp_nx     = samp_q;
        bit_nx      = bit_q;
        shreg_nx    = shreg_q;
        byte_cnt_nx = byte_cnt_q;
        idle_nx     = idle_q;
        err_nx      = err_q;
        ret_gap_nx  = ret_gap_q;
        s0_nx       = s0_q;
        s1_nx       = s1_q;
        buf_nx      = buf_q;
        close_nx    = 1'b0;
        if (tick) begin
            if (samp_q == SAMP_A) s0_nx = rx_s;
            if (samp_q == SAMP_B) s1_nx = rx_s;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_nx    = START;
                        samp_nx     = '0;
                        byte_cnt_nx = '0;
                        buf_nx      = '0;
                        err_nx      = 1'b0;
                        ret_gap_nx  = 1'b0;
                    end
                end
                START: begin
                    samp_nx = samp_q + SW'(1);
                    if (samp_q == SAMP_C && maj) begin
                        state_nx = ret_gap_q ? GAP : IDLE;
                    end else if (samp_q == SAMP_LAST) begin
                        state_nx = DATA;
                        samp_nx  = '0;
                        bit_nx   = '0;
                    end
                end
                DATA: begin
                    samp_nx = samp_q + SW'(1);
                    if (samp_q == SAMP_C) shreg_nx = {maj, shreg_q[7:1]};
                    if (samp_q == SAMP_LAST) begin
                        samp_nx = '0;
                        if (bit_q == 3'd7) state_nx = STOP;
                        else               bit_nx   = bit_q + 3'd1;
                    end
                end
                STOP: begin
                    samp_nx = samp_q + SW'(1);
                    if (samp_q == SAMP_C) begin
                        err_nx = err_q | ~maj;
                        buf_nx[{byte_cnt_q, 3'b000} +: 8] = shreg_q;
                        byte_cnt_nx = byte_cnt_q + LW'(1);
                        if (byte_cnt_nx == LEN_FULL) begin
                            close_nx = 1'b1;
                            state_nx = IDLE;
                        end else begin
                            state_nx = GAP;
                            idle_nx  = '0;
                        end
                    end
                end
                GAP: begin
                    // Low ticks restart a byte without clearing the idle count; only high ticks age the gap.
                    if (!rx_s) begin
                        state_nx   = START;
                        samp_nx    = '0;
                        ret_gap_nx = 1'b1;
                    end else if (idle_q + IW'(1) == IDLE_END) begin
                        close_nx = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        idle_nx = idle_q + IW'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Holding register: a close lands one cycle after its tick, so buf_q is already final.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            data_out      <= '0;
            len_out       <= '0;
            frame_err_out <= 1'b0;
            valid_out     <= 1'b0;
            overrun_out   <= 1'b0;
        end else begin
            overrun_out <= 1'b0;
            if (valid_out && ready_in) valid_out <= 1'b0;
            if (close_q) begin
                if (!valid_out || ready_in) begin
                    data_out      <= buf_q;
                    len_out       <= byte_cnt_q;
                    frame_err_out <= err_q;
                    valid_out     <= 1'b1;
                end else begin
                    overrun_out <= 1'b1;
                end
            end
        end
    end
endmodule
